// File: rtl/muldiv_ctrl_if.sv
// Handshake bundle between the E stage and the multiply/divide unit.
// The pipeline side drives the operation request and reads HI/LO, busy and the D-stage stall.
interface muldiv_ctrl_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        d_is_md;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        md_stall;

    modport master (
        output start, md_op, rs_val, rt_val, flush, d_is_md,
        input  hi, lo, busy, md_stall
    );

    modport slave (
        input  start, md_op, rs_val, rt_val, flush, d_is_md,
        output hi, lo, busy, md_stall
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide unit holding HI/LO, with a fixed-latency busy window
// and a combinational D-stage stall for multiply/divide-class instructions.
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_ctrl_if.slave  md
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             busy_r;

    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [31:0] pend_hi_r;
    logic [31:0] pend_lo_r;
    logic        pend_keep_r;

    logic        accept_s;
    logic        is_md_op_s;
    logic        is_div_s;
    logic        launch_s;
    logic        commit_s;
    logic        md_stall_s;

    logic [63:0] smul_s;
    logic [63:0] umul_s;
    logic        div_signed_s;
    logic        rs_neg_s;
    logic        rt_neg_s;
    logic [31:0] rs_mag_s;
    logic [31:0] rt_mag_s;
    logic [31:0] uquo_s;
    logic [31:0] urem_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;

    assign accept_s   = md.start & ~md.flush & ~busy_r;
    assign is_md_op_s = (md.md_op >= OP_MULT) && (md.md_op <= OP_DIVU);
    assign is_div_s   = (md.md_op == OP_DIV) || (md.md_op == OP_DIVU);
    assign launch_s   = accept_s & is_md_op_s & (state_r == ST_IDLE);
    assign commit_s   = (state_r == ST_RUN) && (cnt_r == CNT_ONE);

    // Full-width products; the signed one uses explicitly sign-extended operands.
    assign smul_s = $signed({{32{md.rs_val[31]}}, md.rs_val}) * $signed({{32{md.rt_val[31]}}, md.rt_val});
    assign umul_s = {32'd0, md.rs_val} * {32'd0, md.rt_val};

    // Signed divide done in sign-magnitude so 0x80000000 / -1 never overflows;
    // a zero divisor is replaced by one only to keep the divider well defined.
    assign div_signed_s = (md.md_op == OP_DIV);
    assign rs_neg_s     = div_signed_s & md.rs_val[31];
    assign rt_neg_s     = div_signed_s & md.rt_val[31];
    assign rs_mag_s     = rs_neg_s ? (32'd0 - md.rs_val) : md.rs_val;
    assign rt_mag_s     = (md.rt_val == 32'd0) ? 32'd1 :
                          (rt_neg_s ? (32'd0 - md.rt_val) : md.rt_val);
    assign uquo_s       = rs_mag_s / rt_mag_s;
    assign urem_s       = rs_mag_s % rt_mag_s;
    assign quo_s        = (rs_neg_s ^ rt_neg_s) ? (32'd0 - uquo_s) : uquo_s;
    assign rem_s        = rs_neg_s ? (32'd0 - urem_s) : urem_s;

    // Select the result captured into the pending registers at launch.
    always_comb begin
        res_hi_s = 32'd0;
        res_lo_s = 32'd0;
        case (md.md_op)
            OP_MULT: begin
                res_hi_s = smul_s[63:32];
                res_lo_s = smul_s[31:0];
            end
            OP_MULTU: begin
                res_hi_s = umul_s[63:32];
                res_lo_s = umul_s[31:0];
            end
            OP_DIV, OP_DIVU: begin
                res_hi_s = rem_s;
                res_lo_s = quo_s;
            end
            default: begin
                res_hi_s = 32'd0;
                res_lo_s = 32'd0;
            end
        endcase
    end

    // State register: FSM state, latency counter and registered busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= (cnt_nxt_s != CNT_ZERO);
        end
    end

    // Next-state logic: load the latency on launch, count down to zero while running.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = is_div_s ? DIV_LOAD : MULT_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            ST_RUN: begin
                if (cnt_r <= CNT_ONE) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Output logic: mfhi/mflo in D must wait while busy, and mthi/mtlo in E never stall.
    always_comb begin
        md_stall_s = 1'b0;
        if (md.d_is_md) begin
            md_stall_s = busy_r | (md.start & is_md_op_s & ~md.flush);
        end else begin
            md_stall_s = 1'b0;
        end
    end

    // HI/LO and pending-result registers; a divide by zero commits nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r        <= 32'd0;
            lo_r        <= 32'd0;
            pend_hi_r   <= 32'd0;
            pend_lo_r   <= 32'd0;
            pend_keep_r <= 1'b0;
        end else begin
            if (launch_s) begin
                pend_hi_r   <= res_hi_s;
                pend_lo_r   <= res_lo_s;
                pend_keep_r <= is_div_s & (md.rt_val == 32'd0);
            end
            if (commit_s) begin
                if (!pend_keep_r) begin
                    hi_r <= pend_hi_r;
                    lo_r <= pend_lo_r;
                end
            end else if (accept_s && (md.md_op == OP_MTHI)) begin
                hi_r <= md.rs_val;
            end else if (accept_s && (md.md_op == OP_MTLO)) begin
                lo_r <= md.rs_val;
            end
        end
    end

    assign md.hi       = hi_r;
    assign md.lo       = lo_r;
    assign md.busy     = busy_r;
    assign md.md_stall = md_stall_s;

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide unit and scheduler for the five-stage pipeline. Accepts mult/multu/div/divu/mthi/mtlo from the E stage and holds HI/LO. It runs each multiply or divide for a fixed latency and raises a D-stage stall whenever a multiply/divide-class instruction would otherwise enter E while the unit is occupied. Exception flushes in the same cycle suppress the launch.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- start  in  1  E-stage holds a valid multiply/divide-class instruction this cycle
- md_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- rs_val  in  32  forwarded rs operand
- rt_val  in  32  forwarded rt operand
- flush  in  1  exception/eret flush; cancels the E-stage instruction this cycle
- d_is_md  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- busy  out  1  an operation is in flight
- md_stall  out  1  stall request for F/D

## Operation
- Reset: hi=0, lo=0, busy=0, internal counter=0, pending registers=0. md_stall=0 when start=0.
- Launch condition: start & ~flush & ~busy, with md_op in 1..4.
- Result computation:
  - Compute the full result at launch into pend_hi/pend_lo.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
- Commit:
  - Counter decrements every edge while nonzero.
  - On the edge where the counter goes 1→0, copy pend_hi/pend_lo into hi/lo.
  - hi/lo keep their old values during the busy period.
- mult: {hi,lo} = signed(rs)×signed(rt), 64-bit. multu: unsigned 64-bit product.
- div/divu: lo = quotient truncated toward zero, hi = remainder carrying the dividend's sign. div uses signed operands, divu unsigned.
- Divide boundary cases:
  - rt_val=0: the operation still occupies DIV_CYCLES, and hi/lo stay unchanged at commit.
  - div of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- mthi/mtlo:
  - Legal when start & ~flush & ~busy.
  - hi (or lo) := rs_val at the next edge. Busy is not asserted.
- start while busy is a pipeline error (prevented by md_stall). The unit ignores it, and the in-flight operation is unaffected.
- flush while busy does not cancel the in-flight operation; that instruction has already retired past E.
- md_stall = d_is_md & (busy | (start & md_op∈1..4 & ~flush)).
  - mthi/mtlo in E do not stall D.
  - mfhi/mflo read hi/lo combinationally and therefore must wait for busy=0.
- busy = (counter≠0), registered.

## Timing
- Launch sampled at edge T0 gives busy=1 for cycles T0+1 … T0+N, where N = MULT_CYCLES or DIV_CYCLES.
- New hi/lo are visible from cycle T0+N+1 together with busy=0.
- A back-to-back launch is accepted at edge T0+N+1 at the earliest.
- mthi/mtlo take effect one cycle after the sampling edge.
- md_stall is combinational from start, md_op, flush, d_is_md and busy. There is no registered delay.
- Asynchronous reset mid-operation:
  - The counter clears immediately and busy drops.
  - hi/lo = 0 and the pending result is discarded.

## Test plan
- Reset, then mult rs=0xFFFFFFFE (−2), rt=3: busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu rs=0xFFFFFFFF, rt=0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles; hi/lo unchanged during busy.
- div rs=−7 (0xFFFFFFF9), rt=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 cycles.
- Divide edge cases:
  - divu rs=7, rt=0 with hi=0x11, lo=0x22 preset via mthi/mtlo: busy 10 cycles, then hi/lo still 0x11/0x22.
  - div 0x80000000/−1: lo=0x80000000, hi=0.
- Stall behaviour:
  - start=1 div, d_is_md=1: md_stall=1 in the start cycle and for all 10 busy cycles, then 0.
  - The same with flush=1: no launch, busy stays 0, md_stall=0.
- Reset mid-operation: assert rst_n=0 at cycle 3 of a mult; busy and hi/lo go to 0 immediately, with no commit after release.
